a0_trace_fifo: RTL and testbench

Downstream observer for the single-cycle core's `a0` output. Every rising edge it compares `a0` with the last value it captured. When the value has changed, it pushes that value into a small FIFO, together with a free-running cycle stamp. A bench, display driver or host link drains the FIFO through a valid/ready stream, so every `a0` transition is logged without stalling the core.

---
 rtl/a0_trace_fifo.sv | 152 +++++++++++++++
 tb/tb_a0_trace_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/a0_trace_fifo.sv
// a0_trace_fifo: watches the core's a0 register and logs every change of value into a small
// FIFO that a consumer drains over a valid/ready stream. The core is never stalled; changes
// that arrive while the FIFO is full are dropped and counted.
//
// Optional feature macro: A0_TRACE_STAMP_EN
//   defined   - a free-running cycle counter is built and each entry carries its capture cycle
//   undefined - no stamp storage or counter; out_stamp is tied to 0
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   asynchronous active-low reset
//   a0         in   observed core a0 value
//   en         in   capture enable (0: no compare, no push)
//   out_valid  out  FIFO head is valid
//   out_ready  in   consumer accepts the head this cycle
//   out_data   out  head a0 value
//   out_stamp  out  head cycle stamp (0 when stamps are not built)
//   count      out  current occupancy
//   overflow   out  sticky: a change was dropped because the FIFO was full
//   drop_cnt   out  number of dropped changes, saturating at 255

module a0_trace_fifo #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned STAMP_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      a0,
    input  logic                       en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [STAMP_WIDTH-1:0]     out_stamp,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            drop_q, drop_d;

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic full;
    logic chg;
    logic push;
    logic pop;
    logic drop;

    assign full      = (count_q == CntW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign chg       = en && (a0 != prev_q);
    // A pop in the same cycle frees the head, so a full FIFO can still take the new value.
    assign push      = chg && (!full || pop);
    assign drop      = chg && full && !pop;

    always_comb begin
        prev_d     = prev_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        // prev follows a0 even on a drop, so a held value is never retried.
        if (chg) begin
            prev_d = a0;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != 8'hff) begin
                drop_d = drop_q + 8'd1;
            end
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            prev_q     <= prev_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Storage is not reset; its contents are meaningless while out_valid is low.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= a0;
        end
    end

    assign out_data = data_mem[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_q;

`ifdef A0_TRACE_STAMP_EN
    logic [STAMP_WIDTH-1:0] cyc_q;
    logic [STAMP_WIDTH-1:0] stamp_mem [DEPTH];

    // Free-running, independent of en; wraps naturally at 2^STAMP_WIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + STAMP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            stamp_mem[wr_ptr_q] <= cyc_q;
        end
    end

    assign out_stamp = stamp_mem[rd_ptr_q];
`else
    assign out_stamp = '0;
`endif

endmodule

// File: tb/tb_a0_trace_fifo.sv
module tb_a0_trace_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int SW    = 16;
`ifdef A0_TRACE_STAMP_EN
    localparam bit StampOn = 1'b1;
`else
    localparam bit StampOn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] a0 = '0;
    logic          en = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [SW-1:0] out_stamp;
    logic [3:0]    count;
    logic          overflow;
    logic [7:0]    drop_cnt;

    a0_trace_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .STAMP_WIDTH(SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a0        (a0),
        .en        (en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_stamp (out_stamp),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] stamp;
    } entry_t;

    entry_t        m_q[$];
    logic [DW-1:0] m_prev = '0;
    int            m_cyc = 0;
    int            m_drops = 0;
    bit            m_ovf = 1'b0;

    task automatic model_clear();
        m_q.delete();
        m_prev  = '0;
        m_cyc   = 0;
        m_drops = 0;
        m_ovf   = 1'b0;
    endtask

    // Model advances on every clock edge taken out of reset.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                entry_t e;
                bit was_full;
                bit do_pop;
                was_full = (m_q.size() == DEPTH);
                do_pop   = (m_q.size() != 0) && out_ready;
                if (do_pop) void'(m_q.pop_front());
                if (en && a0 != m_prev) begin
                    m_prev = a0;
                    if (!was_full || do_pop) begin
                        e.data  = a0;
                        e.stamp = SW'(m_cyc);
                        m_q.push_back(e);
                    end else begin
                        m_drops++;
                        m_ovf = 1'b1;
                    end
                end
                m_cyc = (m_cyc + 1) % (1 << SW);
            end
        end
    end

    // Compare process: every negedge out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("cmp_valid", 64'(out_valid), 64'(m_q.size() != 0));
                check("cmp_count", 64'(count), 64'(m_q.size()));
                check("cmp_overflow", 64'(overflow), 64'(m_ovf));
                check("cmp_drop_cnt", 64'(drop_cnt), 64'(m_drops > 255 ? 255 : m_drops));
                if (m_q.size() != 0) begin
                    check("cmp_data", 64'(out_data), 64'(m_q[0].data));
                    check("cmp_stamp", 64'(out_stamp), StampOn ? 64'(m_q[0].stamp) : 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    // Apply inputs, let one rising edge consume them, return at negedge+1.
    task automatic step(input logic [DW-1:0] a, input logic e, input logic r);
        a0 = a;
        en = e;
        out_ready = r;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_clear();
        a0 = '0;
        en = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst = 1'b1;
    endtask

    initial begin
        // Capture
        do_reset();
        repeat (3) step(32'd0, 1'b1, 1'b0);
        step(32'd5, 1'b1, 1'b0);
        step(32'd5, 1'b1, 1'b0);
        check("cap_count", 64'(count), 64'd1);
        check("cap_data", 64'(out_data), 64'd5);

        // Drain and stamp: changes at edges 0, 3 and 7
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step((k < 3) ? 32'd1 : (k < 7) ? 32'd2 : 32'd3, 1'b1, 1'b0);
        end
        check("stamp_count", 64'(count), 64'd3);
        check("stamp0_data", 64'(out_data), 64'd1);
        check("stamp0", 64'(out_stamp), 64'd0);
        step(32'd3, 1'b1, 1'b1);
        check("stamp1_data", 64'(out_data), 64'd2);
        check("stamp1", 64'(out_stamp), StampOn ? 64'd3 : 64'd0);
        step(32'd3, 1'b1, 1'b1);
        check("stamp2_data", 64'(out_data), 64'd3);
        check("stamp2", 64'(out_stamp), StampOn ? 64'd7 : 64'd0);
        step(32'd3, 1'b1, 1'b1);
        check("stamp_empty", 64'(out_valid), 64'd0);
        // Empty with ready high: nothing moves
        step(32'd3, 1'b1, 1'b1);
        check("empty_ready_count", 64'(count), 64'd0);

        // Overflow
        do_reset();
        for (int v = 1; v <= 10; v++) step(32'(v), 1'b1, 1'b0);
        check("ovf_count", 64'(count), 64'd8);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_drops", 64'(drop_cnt), 64'd2);
        for (int v = 1; v <= 8; v++) begin
            check("ovf_drain", 64'(out_data), 64'(v));
            step(32'd10, 1'b1, 1'b1);
        end
        check("ovf_drained", 64'(count), 64'd0);
        step(32'd10, 1'b1, 1'b0);
        check("ovf_prev_is_10", 64'(count), 64'd0);

        // Full with simultaneous pop and push
        do_reset();
        for (int v = 1; v <= 8; v++) step(32'(v), 1'b1, 1'b0);
        step(32'd9, 1'b1, 1'b1);
        check("fpp_count", 64'(count), 64'd8);
        check("fpp_drops", 64'(drop_cnt), 64'd0);
        check("fpp_head", 64'(out_data), 64'd2);
        for (int i = 0; i < 7; i++) step(32'd9, 1'b1, 1'b1);
        check("fpp_last", 64'(out_data), 64'd9);
        check("fpp_last_count", 64'(count), 64'd1);
        step(32'd9, 1'b1, 1'b1);

        // Enable and reset
        do_reset();
        step(32'd7, 1'b0, 1'b0);
        step(32'd8, 1'b0, 1'b0);
        check("en0_count", 64'(count), 64'd0);
        step(32'd0, 1'b1, 1'b0);
        check("en0_prev_held", 64'(count), 64'd0);
        for (int v = 1; v <= 10; v++) step(32'(v), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(32'd10, 1'b1, 1'b1);
        check("pre_rst_count", 64'(count), 64'd4);
        check("pre_rst_ovf", 64'(overflow), 64'd1);
        #1;
        rst = 1'b0;
        model_clear();
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_ovf", 64'(overflow), 64'd0);
        check("async_rst_drops", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        #1;

        // Saturation: 8 pushes then 300 drops, then more
        do_reset();
        for (int v = 1; v <= 308; v++) step(32'(v), 1'b1, 1'b0);
        check("sat_drops", 64'(drop_cnt), 64'd255);
        for (int v = 309; v <= 313; v++) step(32'(v), 1'b1, 1'b0);
        check("sat_hold", 64'(drop_cnt), 64'd255);
        check("sat_count", 64'(count), 64'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
